// File: rtl/instr_phase_sequencer.sv
// One-hot stage-enable sequencer for the non-pipelined LEGv8 datapath.
// Walks FETCH..WB per instruction, parking in WAIT while the multiplier/divider runs.
module instr_phase_sequencer #(
   parameter int unsigned MAX_STALL_CYCLES = 16,
   parameter int unsigned COUNT_W          = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic               step,
   input  logic               stall,
   input  logic               multiplier_done,
   input  logic               divider_done,
   output logic               fetch_en,
   output logic               read_en,
   output logic               exec_en,
   output logic               mem_read_en,
   output logic               mem_write_en,
   output logic               write_en,
   output logic [2:0]         phase,
   output logic               busy,
   output logic               stall_timeout,
   output logic [COUNT_W-1:0] retired_count
);

   localparam int unsigned WaitW = (MAX_STALL_CYCLES > 1) ? $clog2(MAX_STALL_CYCLES) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_STALL_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StFetch   = 3'd1,
      StDecode  = 3'd2,
      StExecute = 3'd3,
      StWait    = 3'd4,
      StMemRd   = 3'd5,
      StMemWr   = 3'd6,
      StWb      = 3'd7
   } state_e;

   state_e             state_q, state_d;
   logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
   logic               timeout_q, timeout_d;
   logic [COUNT_W-1:0] retired_q, retired_d;
   logic               done;

   assign done = multiplier_done | divider_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
         retired_q  <= retired_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      retired_d  = retired_q;
      unique case (state_q)
         StIdle: begin
            if (!timeout_q && (run || step)) state_d = StFetch;
         end
         StFetch:  state_d = StDecode;
         StDecode: state_d = StExecute;
         StExecute: begin
            // A result already valid in EXECUTE skips the wait phase entirely.
            if (stall && !done) begin
               state_d    = StWait;
               wait_cnt_d = '0;
            end else begin
               state_d = StMemRd;
            end
         end
         StWait: begin
            if (done) begin
               state_d    = StMemRd;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WaitLast) begin
               state_d    = StIdle;
               timeout_d  = 1'b1;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + WaitW'(1);
            end
         end
         StMemRd: state_d = StMemWr;
         StMemWr: state_d = StWb;
         StWb: begin
            retired_d = retired_q + COUNT_W'(1);
            state_d   = run ? StFetch : StIdle;
         end
      endcase
   end

   always_comb begin
      fetch_en     = 1'b0;
      read_en      = 1'b0;
      exec_en      = 1'b0;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      write_en     = 1'b0;
      unique case (state_q)
         StFetch:   fetch_en     = 1'b1;
         StDecode:  read_en      = 1'b1;
         StExecute: exec_en      = 1'b1;
         StMemRd:   mem_read_en  = 1'b1;
         StMemWr:   mem_write_en = 1'b1;
         StWb:      write_en     = 1'b1;
         default:   ;
      endcase
   end

   assign phase         = state_q;
   assign busy          = (state_q != StIdle);
   assign stall_timeout = timeout_q;
   assign retired_count = retired_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert ($onehot0({fetch_en, read_en, exec_en, mem_read_en, mem_write_en, write_en}))
         else $error("stage enables not one-hot");
      end
   end
`endif

endmodule

// File: tb/tb_instr_phase_sequencer.sv
// Randomized scoreboard bench for instr_phase_sequencer: the driver predicts each
// instruction's outcome, a monitor checks strobes, latency and retired count.
module tb_instr_phase_sequencer;

   localparam int MAX  = 16;
   localparam int CW   = 4;
   localparam int WRAP = 1 << CW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          run = 1'b0;
   logic          step = 1'b0;
   logic          stall = 1'b0;
   logic          multiplier_done = 1'b0;
   logic          divider_done = 1'b0;
   logic          fetch_en, read_en, exec_en, mem_read_en, mem_write_en, write_en;
   logic [2:0]    phase;
   logic          busy, stall_timeout;
   logic [CW-1:0] retired_count;

   instr_phase_sequencer #(
      .MAX_STALL_CYCLES(MAX),
      .COUNT_W         (CW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .run            (run),
      .step           (step),
      .stall          (stall),
      .multiplier_done(multiplier_done),
      .divider_done   (divider_done),
      .fetch_en       (fetch_en),
      .read_en        (read_en),
      .exec_en        (exec_en),
      .mem_read_en    (mem_read_en),
      .mem_write_en   (mem_write_en),
      .write_en       (write_en),
      .phase          (phase),
      .busy           (busy),
      .stall_timeout  (stall_timeout),
      .retired_count  (retired_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_cnt = 0;

   // One entry per fetched instruction: timeout or retire, fetch-to-event latency, count after.
   typedef struct {
      bit to;
      int lat;
      int cnt;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input longint got, input longint want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic set_done(input bit v);
      if (v) begin
         case ($urandom % 3)
            0:       {multiplier_done, divider_done} = 2'b10;
            1:       {multiplier_done, divider_done} = 2'b01;
            default: {multiplier_done, divider_done} = 2'b11;
         endcase
      end else begin
         {multiplier_done, divider_done} = 2'b00;
      end
   endtask

   task automatic rnd_dp();
      stall = 1'($urandom);
      set_done(1'($urandom));
   endtask

   task automatic rnd_ctl();
      run  = 1'($urandom);
      step = 1'($urandom);
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      run   = 1'b0;
      step  = 1'b0;
      stall = 1'b0;
      set_done(1'b0);
      repeat (n) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      exp_cnt = 0;
   endtask

   task automatic wait_fetch(output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!fetch_en && waited < 8);
   endtask

   // Called at the FETCH-cycle negedge. s: uses mult/div; d: WAIT cycle carrying done
   // (0 = done already in EXECUTE, >MAX = never); cont: run level seen in WB.
   task automatic do_instr(input bit s, input int d, input bit cont);
      exp_t e;
      int   n;
      e.to = s && (d > MAX);
      n    = (s && !e.to) ? d : 0;
      e.lat = e.to ? 3 + MAX : 5 + n;
      if (!e.to) exp_cnt = (exp_cnt + 1) % WRAP;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
      rnd_ctl(); rnd_dp();
      @(negedge clk); rnd_ctl(); rnd_dp();
      @(negedge clk); rnd_ctl(); stall = s; set_done(s ? (d == 0) : 1'($urandom));
      if (s && d != 0) begin
         for (int w = 1; w <= MAX && w <= d; w++) begin
            @(negedge clk);
            rnd_ctl();
            stall = 1'b1;
            set_done(w == d);
         end
      end
      if (e.to) return;
      @(negedge clk); rnd_ctl(); rnd_dp();
      @(negedge clk); rnd_ctl(); rnd_dp();
      @(negedge clk); run = cont; step = 1'b0; rnd_dp();
   endtask

   task automatic next_instr(input bit cont);
      int w;
      if (!cont) begin
         @(negedge clk);
         check("parked_idle_busy", busy, 0);
         step = 1'b0;
         rnd_dp();
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            rnd_dp();
         end
         if (1'($urandom)) step = 1'b1;
         else begin
            run  = 1'b1;
            step = 1'($urandom);
         end
      end
      wait_fetch(w);
      check("fetch_gap", w, 1);
   endtask

   initial begin : monitor
      int        fetch_cyc;
      bit        pend;
      int        pend_cnt;
      bit        prev_to;
      exp_t      e;
      logic [5:0] en, en_exp;
      fetch_cyc = 0;
      pend      = 1'b0;
      pend_cnt  = 0;
      prev_to   = 1'b0;
      forever begin
         @(negedge clk);
         en = {fetch_en, read_en, exec_en, mem_read_en, mem_write_en, write_en};
         case (phase)
            3'd1:    en_exp = 6'b100000;
            3'd2:    en_exp = 6'b010000;
            3'd3:    en_exp = 6'b001000;
            3'd5:    en_exp = 6'b000100;
            3'd6:    en_exp = 6'b000010;
            3'd7:    en_exp = 6'b000001;
            default: en_exp = 6'b000000;
         endcase
         check("phase_enables", en, en_exp);
         check("busy_vs_phase", busy, phase != 3'd0);
         if (pend) begin
            check("retired_count", retired_count, pend_cnt);
            pend = 1'b0;
         end
         if (fetch_en) fetch_cyc = cyc;
         if (write_en) begin
            if (exp_q.size() == 0) check("unexpected_write_en", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("wb_not_timeout", e.to, 0);
               check("wb_latency", cyc - fetch_cyc, e.lat);
               pend     = 1'b1;
               pend_cnt = e.cnt;
            end
         end
         if (stall_timeout && !prev_to) begin
            if (exp_q.size() == 0) check("unexpected_timeout", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("timeout_expected", e.to, 1);
               check("timeout_latency", cyc - fetch_cyc, e.lat);
               check("timeout_count", retired_count, e.cnt);
            end
         end
         prev_to = stall_timeout;
      end
   end

   initial begin : driver
      int w;
      bit s, c;
      int d;

      apply_reset(2);
      check("reset_phase", phase, 0);
      check("reset_busy", busy, 0);
      check("reset_timeout", stall_timeout, 0);
      check("reset_count", retired_count, 0);

      // Back-to-back run: fetches in cycles 1, 7, 13.
      run = 1'b1;
      wait_fetch(w);
      check("first_fetch_cycle", w, 1);
      do_instr(1'b0, 0, 1'b1);
      wait_fetch(w);
      check("fetch_gap_run", w, 1);
      do_instr(1'b0, 0, 1'b1);
      wait_fetch(w);
      check("fetch_gap_run", w, 1);
      check("count_at_cycle13", retired_count, 2);

      // Four WAIT cycles, then park and restart.
      do_instr(1'b1, 4, 1'b0);
      next_instr(1'b0);

      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom);
         d = int'($urandom_range(0, MAX));
         c = (i == 39) ? 1'b0 : 1'($urandom);
         do_instr(s, d, c);
         if (i != 39) next_instr(c);
      end
      repeat (3) @(negedge clk);
      check("count_after_random", retired_count, exp_cnt);

      // Abort in MEM_WR: no writeback may follow.
      stall = 1'b0;
      set_done(1'b0);
      run = 1'b1;
      w = 0;
      while (!mem_write_en && w < 12) begin
         @(negedge clk);
         w++;
      end
      check("reached_mem_wr", mem_write_en, 1);
      reset = 1'b1;
      run   = 1'b0;
      @(negedge clk);
      check("abort_phase", phase, 0);
      check("abort_enables", {fetch_en, read_en, exec_en, mem_read_en, mem_write_en, write_en}, 0);
      check("abort_count", retired_count, 0);
      check("abort_busy", busy, 0);
      reset = 1'b0;
      exp_cnt = 0;
      repeat (8) @(negedge clk);

      // Watchdog: one good instruction, then a stall that never completes.
      run = 1'b1;
      wait_fetch(w);
      check("fetch_gap", w, 1);
      do_instr(1'b0, 0, 1'b1);
      wait_fetch(w);
      check("fetch_gap", w, 1);
      do_instr(1'b1, MAX + 1, 1'b1);
      run  = 1'b1;
      step = 1'b0;
      w = 0;
      repeat (30) begin
         @(negedge clk);
         rnd_dp();
         step = 1'($urandom);
         if (fetch_en) w++;
      end
      check("fetches_after_timeout", w, 0);
      check("timeout_sticky", stall_timeout, 1);
      check("count_after_timeout", retired_count, 1);
      check("idle_after_timeout", busy, 0);

      apply_reset(1);
      check("timeout_cleared", stall_timeout, 0);
      repeat (2) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL sim_timeout: bench did not finish, cycle %0d", cyc);
      $fatal(1, "simulation time limit");
   end

endmodule
